serial_adder: RTL and testbench

Bit-serial ripple adder that adds two WIDTH-bit operands one bit per clock, LSB first. Each bit uses a full adder built from two `half_adder` instances plus a carry flip-flop. The block sits directly downstream of the `half_adder` stage and reuses it as its per-bit datapath. A start/busy/done handshake makes it a self-contained arithmetic unit for the lab datapath and for later multiplier work.

---
 rtl/serial_adder.sv | 142 ++++++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands one bit per clock,
// LSB first, using two chained half adders and a carry flip-flop.
// A start/busy/done handshake wraps the datapath; sum/cout are registered
// and only change on the completion edge.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only needs to reach WIDTH-1; keep it at least one bit wide.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_carry;
  logic [WIDTH-1:0] w_acc_next;

  // Full adder for the current bit: (a ^ b) then (^ carry), carries ORed.
  half_adder u_ha0 (
    .a (r_a_sh[0]),
    .b (r_b_sh[0]),
    .s (w_s1),
    .c (w_c1)
  );

  half_adder u_ha1 (
    .a (w_s1),
    .b (r_c),
    .s (w_s),
    .c (w_c2)
  );

  assign w_carry = w_c1 | w_c2;

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign w_acc_next = w_s;
    end else begin : g_acc_wn
      assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM and serial datapath; all outputs come straight from registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_c     <= cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_c    <= w_carry;
          r_acc  <= w_acc_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            // Last bit: publish the result including the bit just computed.
            r_sum   <= w_acc_next;
            r_cout  <= w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances, scoreboard
// of expected {cout,sum} pushed on accept and popped on done.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int excl_bad = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // busy and done must never be high together on either instance
  always @(negedge clk) begin
    if ((busy8 === 1'b1 && done8 === 1'b1) || (busy1 === 1'b1 && done1 === 1'b1))
      excl_bad++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit disturb);
    logic [8:0] exp;
    int n, nb;
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(ci));
    tick;
    start8 = 1'b0;
    n = 0; nb = 0;
    while (done8 !== 1'b1 && n < 20) begin
      if (busy8 === 1'b1) nb++;
      if (disturb && n == 3) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1; end
      if (disturb && n == 4) start8 = 1'b0;
      tick;
      n++;
    end
    chk("latency8", n, 8);
    chk("busy_cycles8", nb, 8);
    chk("busy_at_done8", busy8, 1'b0);
    chk("sb_nonempty8", (q8.size() != 0), 1'b1);
    if (q8.size() != 0) begin
      exp = q8.pop_front();
      chk("sum8", sum8, exp[7:0]);
      chk("cout8", cout8, exp[8]);
    end
    tick;
    chk("done_one_cycle8", done8, 1'b0);
  endtask

  task automatic run1(input logic a, input logic b, input logic ci);
    logic [1:0] exp;
    int n;
    a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
    q1.push_back({1'b0, a} + {1'b0, b} + 2'(ci));
    tick;
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    chk("latency1", n, 1);
    exp = q1.pop_front();
    chk("sum1", sum1, exp[0]);
    chk("cout1", cout1, exp[1]);
    tick;
    chk("done_one_cycle1", done1, 1'b0);
  endtask

  initial begin
    int t, nd, hold_bad, extra_done;
    int dt[3];
    logic [8:0] e;

    // Reset with start asserted: reset must win
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h05; cin8 = 1'b0;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    tick; tick;
    chk("rst_outs8", {busy8, done8, cout8, sum8}, 11'h000);
    chk("rst_outs1", {busy1, done1, cout1, sum1}, 4'h0);
    rst_n = 1'b1; start8 = 1'b0; start1 = 1'b0;
    tick;
    chk("idle_after_rst8", busy8, 1'b0);

    // Basic additions
    run8(8'h03, 8'h05, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1, 1'b0);
    run8(8'h00, 8'h00, 1'b0, 1'b0);

    // start held high: one accept per 10 cycles, sum holds between completions
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 3; k++) q8.push_back(9'h030);
    nd = 0; hold_bad = 0; t = 0;
    while (nd < 3 && t < 60) begin
      tick;
      t++;
      if (done8 === 1'b1) begin
        dt[nd] = t;
        e = q8.pop_front();
        chk("cont_sum8", {cout8, sum8}, e);
        nd++;
      end else if (!(nd == 0 && t < 9) && sum8 !== 8'h30) begin
        hold_bad++;
      end
    end
    start8 = 1'b0;
    chk("cont_count", nd, 3);
    chk("cont_first", dt[0], 9);
    chk("cont_period1", dt[1] - dt[0], 10);
    chk("cont_period2", dt[2] - dt[1], 10);
    chk("cont_hold", hold_bad, 0);
    tick; tick; tick;
    chk("cont_idle", busy8, 1'b0);

    // start and operand changes during ADD are ignored
    run8(8'h12, 8'h34, 1'b0, 1'b1);
    extra_done = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (done8 === 1'b1) extra_done++;
    end
    chk("no_second_done", extra_done, 0);
    chk("hold_after_ignore", sum8, 8'h46);

    // Reset mid-ADD at bit 4 aborts the operation
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick; tick; tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_outs", {busy8, done8, cout8, sum8}, 11'h000);
    extra_done = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (done8 === 1'b1) extra_done++;
    end
    chk("abort_no_done", extra_done, 0);
    chk("abort_sum_held", sum8, 8'h00);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);

    // WIDTH=1 full-adder truth table
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      run1(v[2], v[1], v[0]);
    end

    chk("busy_done_exclusive", excl_bad, 0);
    chk("sb_drained", q8.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
